seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector: the next generation of the team's fixed sequence-detector FSM. It samples a 1-bit serial input on each enabled clock and compares the last PAT_W bits against a runtime-loadable pattern. It reports each match as a one-cycle pulse and as a sticky detect flag, with selectable overlapping or non-overlapping matching. It sits between the serial front-end and the control logic that consumes detect events.

## Interface
- PAT_W, 4: pattern length in bits, 2..16.
- PATTERN, 4'b1011: reset value of the pattern register, PAT_W bits. MSB is the oldest bit.
- CNT_W, 8: match counter width, present only with SEQDET_COUNT_EN.

- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  1  serial data bit.
- en  input  1  sample enable; `in` is consumed only on edges where en=1.
- overlap  input  1  1 = overlapping matches allowed; 0 = the window restarts after each match.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern.
- clear  input  1  clears out and match_count.
- out  output  1  sticky detect flag.
- match_pulse  output  1  high for exactly one cycle after each match.
- match_count  output  CNT_W  saturating match count (SEQDET_COUNT_EN only).

## Operation
- State registers:
  - pat[PAT_W-1:0], the pattern.
  - win[PAT_W-1:0], the shift window; the new bit enters at the LSB.
  - fill, 0..PAT_W, saturating; counts the valid bits in win.
  - out, match_pulse, match_count.
- On reset assertion:
  - pat=PATTERN, win=0, fill=0.
  - out=0, match_pulse=0, match_count=0.
- Edge with pat_load=1 (highest priority among the sync inputs):
  - pat<=pat_in, win<=0, fill<=0, match_pulse<=0.
  - `in` is not consumed, even if en=1.
  - out and match_count are unchanged.
- Edge with en=1, pat_load=0:
  - nwin={win[PAT_W-2:0],in}.
  - nfill=min(fill+1,PAT_W).
  - hit = (nfill==PAT_W) && (nwin==pat).
- If hit:
  - match_pulse<=1 and out<=1.
  - match_count<=match_count+1, holding at all-ones (no wrap).
  - Window update:
    - overlap=1: win<=nwin, fill<=PAT_W.
    - overlap=0: win<=0, fill<=0.
- If no hit: win<=nwin, fill<=nfill, match_pulse<=0.
- Edge with en=0, pat_load=0: win and fill hold, match_pulse<=0.
- clear=1 at an edge forces out<=0 and match_count<=0.
  - clear takes priority over a simultaneous hit for out and match_count.
  - match_pulse still reports that hit.
- overlap is sampled per edge. Changing it mid-stream affects only the next hit.
- A match can only occur once PAT_W bits have been consumed since reset, pattern load, or a non-overlapping match.

## Timing
- Latency: the bit completing a pattern is sampled at edge N. match_pulse and out are high after edge N and visible during cycle N+1.
- match_pulse lasts exactly one cycle per hit.
- Back-to-back hits are possible in overlap mode when the pattern is periodic (e.g. all-ones pattern: one hit per enabled cycle).
- Minimum hit spacing in non-overlap mode: PAT_W enabled cycles.
- Reset assertion mid-stream discards the partial window immediately, asynchronously.
- The first sample after reset deassertion is taken at the first rising edge with en=1.
- All outputs are registered; there is no combinational path from an input to an output.

## Configuration
- SEQDET_COUNT_EN defined:
  - match_count port and the CNT_W-bit saturating counter are present.
  - clear resets both out and match_count.
- SEQDET_COUNT_EN undefined:
  - match_count port is absent and no counter logic is built.
  - clear affects only out.
  - All other behaviour is identical.

## Test plan
All scenarios use defaults: PAT_W=4, PATTERN=1011, en=1, and SEQDET_COUNT_EN defined unless noted.
- Reset:
  - Stimulus: hold reset=0 for 2 cycles with in toggling.
  - Required: out=0, match_pulse=0, match_count=0 throughout; no match on the 4 edges after release unless the input bits 1,0,1,1 actually arrive.
- Basic detect:
  - Stimulus: input 1,0,1,1 then 1.
  - Required: match_pulse=1 only in the cycle after the 4th bit; out=1 from then on and held; match_count=1.
- Overlap vs non-overlap:
  - Stimulus: input 1,0,1,1,0,1,1 with overlap=1.
  - Required: pulses after bits 4 and 7; match_count=2.
  - Same stream with overlap=0: a single pulse after bit 4; match_count=1.
- Enable gating:
  - Stimulus: input 1,0 with en=1, then 3 cycles with en=0 and in=0, then 1,1 with en=1.
  - Required: pulse after the final bit; nothing during the en=0 cycles.
- Pattern load:
  - Stimulus: pat_load with pat_in=0110 midway through 1,0,1; then input 0,1,1,0.
  - Required: no match on the old partial window; pulse after the 4th new bit.
- Clear collision and saturation:
  - Stimulus: clear=1 on the same edge as a hit.
  - Required: out=0, match_count=0, match_pulse=1.
  - With CNT_W=2 and 5 hits: match_count holds at 3.
  - With SEQDET_COUNT_EN undefined: the module elaborates without the match_count port.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with sticky flag and pulse (optional counter: SEQDET_COUNT_EN)
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011
`ifdef SEQDET_COUNT_EN
    ,
    parameter int               CNT_W   = 8
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    input  logic             en,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clear,
`ifdef SEQDET_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             out,
    output logic             match_pulse
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  win;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  nwin;
    logic [FILL_W-1:0] nfill;
    logic              hit;

    // Candidate window after consuming `in`, and whether it completes a match
    always_comb begin
        nwin  = {win[PAT_W-2:0], in};
        nfill = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit   = en && !pat_load && (nfill == FILL_FULL) && (nwin == pat);
    end

    // Pattern register and shift window; a non-overlapping hit restarts the window
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat  <= PATTERN;
            win  <= '0;
            fill <= '0;
        end else if (pat_load) begin
            pat  <= pat_in;
            win  <= '0;
            fill <= '0;
        end else if (en) begin
            if (hit && !overlap) begin
                win  <= '0;
                fill <= '0;
            end else begin
                win  <= nwin;
                fill <= nfill;
            end
        end
    end

    // One-cycle pulse per hit, sticky flag cleared only by clear (clear wins over a hit)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            match_pulse <= 1'b0;
            out         <= 1'b0;
        end else begin
            match_pulse <= hit;
            if (clear) begin
                out <= 1'b0;
            end else if (hit) begin
                out <= 1'b1;
            end
        end
    end

`ifdef SEQDET_COUNT_EN
    // Saturating hit counter; holds at all-ones instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            match_count <= '0;
        end else if (clear) begin
            match_count <= '0;
        end else if (hit && !(&match_count)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param (count checks need SEQDET_COUNT_EN)
module tb_seq_detect_param;

    localparam int PAT_W = 4;
    localparam int CNT_MAX = 255;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic       ovl = 1'b1;
    logic       load = 1'b0;
    logic [3:0] pin = 4'b0000;
    logic       clr = 1'b0;
    logic       out_q;
    logic       pulse_q;
`ifdef SEQDET_COUNT_EN
    logic [7:0] cnt_q;
`endif

    int n_checks = 0;
    int n_pass = 0;

    seq_detect_param dut (
        .clock       (clock),
        .reset       (rst_n),
        .in          (din),
        .en          (en),
        .overlap     (ovl),
        .pat_load    (load),
        .pat_in      (pin),
        .clear       (clr),
`ifdef SEQDET_COUNT_EN
        .match_count (cnt_q),
`endif
        .out         (out_q),
        .match_pulse (pulse_q)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       din;
        logic       en;
        logic       ovl;
        logic       load;
        logic [3:0] pin;
        logic       clr;
        logic       ep;
        logic       eo;
        int         ec;
    } vec_t;

    vec_t vecs[$];

    // reference model: history of bits consumed since the last restart
    bit   m_hist[$];
    logic [3:0] m_pat;
    bit   m_out;
    bit   m_pulse;
    int   m_cnt;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic check_outs(input string name, input bit ep, input bit eo, input int ec);
        check({name, ".pulse"}, int'(pulse_q), int'(ep));
        check({name, ".out"}, int'(out_q), int'(eo));
`ifdef SEQDET_COUNT_EN
        check({name, ".count"}, int'(cnt_q), ec);
`endif
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_pat = 4'b1011;
        m_out = 0;
        m_pulse = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit b, input bit e, input bit ov, input bit ld,
                              input logic [3:0] p, input bit c);
        bit hit = 0;
        if (ld) begin
            m_pat = p;
            m_hist.delete();
        end else if (e) begin
            m_hist.push_back(b);
            if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
            if (m_hist.size() == PAT_W) begin
                int v = 0;
                foreach (m_hist[k]) v = v * 2 + int'(m_hist[k]);
                hit = (v == int'(m_pat));
            end
            if (hit && !ov) m_hist.delete();
        end
        m_pulse = hit;
        if (c) begin
            m_out = 0;
            m_cnt = 0;
        end else if (hit) begin
            m_out = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic step(input bit b, input bit e, input bit ov, input bit ld,
                        input logic [3:0] p, input bit c);
        din = b; en = e; ovl = ov; load = ld; pin = p; clr = c;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din = 0; en = 0; load = 0; clr = 0; ovl = 1;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic add(input bit b, input bit e, input bit ov, input bit ld, input logic [3:0] p,
                       input bit c, input bit ep, input bit eo, input int ec);
        vec_t v;
        v.din = b; v.en = e; v.ovl = ov; v.load = ld; v.pin = p; v.clr = c;
        v.ep = ep; v.eo = eo; v.ec = ec;
        vecs.push_back(v);
    endtask

    initial begin
        // basic detect
        add(1,1,1,0,4'h0,0, 0,0,0); add(0,1,1,0,4'h0,0, 0,0,0);
        add(1,1,1,0,4'h0,0, 0,0,0); add(1,1,1,0,4'h0,0, 1,1,1);
        add(1,1,1,0,4'h0,0, 0,1,1);
        // overlap stream 1,0,1,1,0,1,1
        add(1,1,1,1,4'b1011,0, 0,1,1);
        add(1,1,1,0,4'h0,0, 0,1,1); add(0,1,1,0,4'h0,0, 0,1,1);
        add(1,1,1,0,4'h0,0, 0,1,1); add(1,1,1,0,4'h0,0, 1,1,2);
        add(0,1,1,0,4'h0,0, 0,1,2); add(1,1,1,0,4'h0,0, 0,1,2);
        add(1,1,1,0,4'h0,0, 1,1,3);
        add(0,0,1,0,4'h0,1, 0,0,0);
        // non-overlap, same stream
        add(0,1,0,1,4'b1011,0, 0,0,0);
        add(1,1,0,0,4'h0,0, 0,0,0); add(0,1,0,0,4'h0,0, 0,0,0);
        add(1,1,0,0,4'h0,0, 0,0,0); add(1,1,0,0,4'h0,0, 1,1,1);
        add(0,1,0,0,4'h0,0, 0,1,1); add(1,1,0,0,4'h0,0, 0,1,1);
        add(1,1,0,0,4'h0,0, 0,1,1);
        // enable gating
        add(0,1,1,1,4'b1011,0, 0,1,1);
        add(1,1,1,0,4'h0,0, 0,1,1); add(0,1,1,0,4'h0,0, 0,1,1);
        add(0,0,1,0,4'h0,0, 0,1,1); add(0,0,1,0,4'h0,0, 0,1,1);
        add(0,0,1,0,4'h0,0, 0,1,1);
        add(1,1,1,0,4'h0,0, 0,1,1); add(1,1,1,0,4'h0,0, 1,1,2);
        // clear colliding with a hit
        add(0,1,1,1,4'b1011,0, 0,1,2);
        add(1,1,1,0,4'h0,0, 0,1,2); add(0,1,1,0,4'h0,0, 0,1,2);
        add(1,1,1,0,4'h0,0, 0,1,2); add(1,1,1,0,4'h0,1, 1,0,0);
        // pattern load mid-stream; `in`=1 during load is not consumed
        add(1,1,1,0,4'h0,0, 0,0,0); add(0,1,1,0,4'h0,0, 0,0,0);
        add(1,1,1,0,4'h0,0, 0,0,0);
        add(1,1,1,1,4'b0110,0, 0,0,0);
        add(0,1,1,0,4'h0,0, 0,0,0); add(1,1,1,0,4'h0,0, 0,0,0);
        add(1,1,1,0,4'h0,0, 0,0,0); add(0,1,1,0,4'h0,0, 1,1,1);
        add(1,1,1,0,4'h0,0, 0,1,1);

        // reset held with toggling input
        rst_n = 1'b0;
        en = 1;
        for (int i = 0; i < 2; i++) begin
            din = ~din;
            @(posedge clock);
            #1;
            check_outs($sformatf("reset_hold%0d", i), 0, 0, 0);
        end
        rst_n = 1'b1;
        model_reset();
        // after release: only the real 1,0,1,1 sequence hits
        step(1,1,1,0,4'h0,0); check_outs("post_rst0", 0, 0, 0);
        step(0,1,1,0,4'h0,0); check_outs("post_rst1", 0, 0, 0);
        step(1,1,1,0,4'h0,0); check_outs("post_rst2", 0, 0, 0);
        step(1,1,1,0,4'h0,0); check_outs("post_rst3", 1, 1, 1);

        // table vectors
        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].din, vecs[i].en, vecs[i].ovl, vecs[i].load, vecs[i].pin, vecs[i].clr);
            check_outs($sformatf("vec%0d", i), vecs[i].ep, vecs[i].eo, vecs[i].ec);
        end

        // saturation with periodic all-ones pattern: one hit per enabled cycle
        do_reset();
        step(0,1,1,1,4'b1111,1);
        for (int i = 0; i < 3; i++) step(1,1,1,0,4'h0,0);
        for (int i = 0; i < CNT_MAX + 5; i++) step(1,1,1,0,4'h0,0);
        check_outs("saturate", 1, 1, CNT_MAX);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        model_reset();

        // randomized stream against the reference model
        begin
            logic [3:0] p0;
            p0 = 4'($urandom_range(0, 15));
            step(0,1,1,1,p0,0);
            model_step(0,1,1,1,p0,0);
            for (int i = 0; i < 3000; i++) begin
                bit b, e, ov, ld, c;
                logic [3:0] p;
                b  = ($urandom_range(0, 99) < 60);
                e  = ($urandom_range(0, 99) < 85);
                ov = ($urandom_range(0, 99) < 60);
                ld = ($urandom_range(0, 99) < 2);
                c  = ($urandom_range(0, 99) < 3);
                p  = 4'($urandom_range(0, 15));
                step(b, e, ov, ld, p, c);
                model_step(b, e, ov, ld, p, c);
                check_outs($sformatf("rand%0d", i), m_pulse, m_out, m_cnt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
